am386_cycle_ctrl: RTL and testbench
===================================

AM386_CYCLE_CTRL -- requirements
Module: am386_cycle_ctrl

Interface
REQ-001 SHALL have parameter MEM_WS, default 1, wait states for non-ROM memory cycles (0..15).
REQ-002 SHALL have parameter ROM_WS, default 3, wait states for ROM cycles (0..15).
REQ-003 SHALL have parameter IO_WS, default 4, wait states for I/O cycles (0..15).
REQ-004 SHALL have parameter ROM_PAGE, default 8'hFF, value of addr[23:16] that selects ROM.
REQ-005 SHALL have parameter HOLD_TO, default 16, maximum T-states to wait for hlda.
REQ-006 SHALL have port SYS_CLK, input, 1, the 50 MHz system clock; all state is updated on its rising edge.
REQ-007 SHALL have port user_reset_button, input, 1, reset: asynchronous, active-high.
REQ-008 SHALL have port t_tick, input, 1, a one-SYS_CLK pulse marking each CPU T-state boundary.
REQ-009 SHALL have port ads_n, input, 1, CPU address strobe, active-low.
REQ-010 SHALL have ports mio, dc and wr, each an input of width 1, carrying CPU bus cycle definition.
REQ-011 SHALL have port lock_n, input, 1, CPU bus lock, active-low.
REQ-012 SHALL have port addr, input, 23, CPU address bits [23:1].
REQ-013 SHALL have port hlda, input, 1, CPU hold acknowledge.
REQ-014 SHALL have port dma_req, input, 1, bus request from the external requester.
REQ-015 SHALL have port ready_n, output, 1, CPU READY#, active-low.
REQ-016 SHALL have port na_n, output, 1, CPU NA#; constant 1 (no pipelining).
REQ-017 SHALL have port hold, output, 1, CPU HOLD.
REQ-018 SHALL have port dma_gnt, output, 1, bus granted to the requester.
REQ-019 SHALL have ports mem_sel, rom_sel and io_sel, each an output of width 1, a one-hot decode valid during a cycle.
REQ-020 SHALL have port status_led, output, 8, status indication.

Function
REQ-021 SHALL act only on SYS_CLK edges where t_tick=1, except for the asynchronous reset.
REQ-022 SHALL implement states IDLE, WAIT, RDY, HREQ, HGNT and HREL.
REQ-023 In IDLE, on a tick with ads_n=0, SHALL latch the decode and load a wait counter with the WS for the decoded cycle type.
REQ-024 SHALL go from IDLE to RDY if the WS is 0, and from IDLE to WAIT otherwise.
REQ-025 Decode: rom_sel = mio & addr[23:16]==ROM_PAGE; mem_sel = mio & !rom_sel; io_sel = !mio & dc.
REQ-026 Interrupt-acknowledge cycles (mio=0, dc=0) SHALL use IO_WS with all selects at 0.
REQ-027 Halt/shutdown cycles (mio=1, dc=0, wr=1) SHALL use 0 wait states, SHALL NOT assert any select, and SHALL set the halt flag.
REQ-028 In WAIT, the counter SHALL decrement once per tick, and the block SHALL enter RDY on the tick where the counter is 1.
REQ-029 ready_n SHALL be 0 exactly during RDY, for one T-state.
REQ-030 A cycle with N wait states latched at tick k SHALL drive ready_n low from the edge at tick k+N until the edge at tick k+N+1.
REQ-031 From RDY, the next tick SHALL return the block to IDLE and clear all selects.
REQ-032 An ads_n=0 seen on the RDY-exit tick SHALL be accepted as a new cycle, with the same rules as IDLE.
REQ-033 Arbitration: in IDLE on a tick with dma_req=1, ads_n=1 and lock_n=1, the block SHALL enter HREQ and set hold=1.
REQ-034 If a CPU cycle and dma_req occur on the same tick, the CPU cycle SHALL win.
REQ-035 In HREQ, hlda=1 on a tick SHALL move the block to HGNT and set dma_gnt=1.
REQ-036 If hlda is not seen within HOLD_TO ticks of HREQ, the block SHALL set the sticky err flag, drop hold, and return to IDLE.
REQ-037 In HGNT, dma_req=0 on a tick SHALL clear dma_gnt and hold and move the block to HREL.
REQ-038 In HREL, hlda=0 on a tick SHALL return the block to IDLE.
REQ-039 An ads_n=0 seen while in HGNT or HREL (i.e. while hlda=1) SHALL be ignored and SHALL set err.
REQ-040 status_led SHALL be {last mio, dc, wr, rom_sel, err, halt, dma_gnt, state!=IDLE}.
REQ-041 The last-cycle fields of status_led SHALL update when a cycle is latched.
REQ-042 err and halt SHALL clear only on reset.

Reset
REQ-043 While user_reset_button=1, outputs SHALL be ready_n=1, na_n=1, hold=0, dma_gnt=0, all selects=0, status_led=0, state=IDLE, counter=0.
REQ-044 Reset asserted mid-cycle or mid-hold SHALL abort immediately to the REQ-043 values.
REQ-045 After reset, the first cycle SHALL be accepted on the first tick with ads_n=0.

Verification
REQ-046 Memory read at addr 0x001000 (mio=1, dc=1, wr=0), MEM_WS=1, ADS at tick k -> mem_sel=1 and ready_n low from tick k+1 to k+2.
REQ-047 Fetch at addr 0xFFFFF0 with ROM_WS=3 -> rom_sel=1, ready_n low exactly one T-state beginning at tick k+3, then IDLE.
REQ-048 Halt cycle (mio=1, dc=0, wr=1) -> ready_n low from tick k, status_led[2]=1 sticky.
REQ-049 dma_req=1 with lock_n=0 -> hold stays 0; after lock_n=1, hold=1; hlda=1 -> dma_gnt=1; dma_req=0 -> hold=0, then hlda=0 -> IDLE.
REQ-050 hold raised with hlda held 0 -> after 16 ticks hold=0 and status_led[3]=1.
REQ-051 Reset asserted during WAIT of an I/O cycle -> ready_n=1, io_sel=0 immediately; the next ADS is serviced normally.

Source files
------------

// File: rtl/am386_cycle_ctrl_if.sv
// am386_cycle_ctrl_if: CPU bus, arbitration and status signals of the 386 cycle controller
interface am386_cycle_ctrl_if;
    logic        t_tick;
    logic        ads_n;
    logic        mio;
    logic        dc;
    logic        wr;
    logic        lock_n;
    logic [23:1] addr;
    logic        hlda;
    logic        dma_req;
    logic        ready_n;
    logic        na_n;
    logic        hold;
    logic        dma_gnt;
    logic        mem_sel;
    logic        rom_sel;
    logic        io_sel;
    logic [7:0]  status_led;
    modport slave (
        input  t_tick, ads_n, mio, dc, wr, lock_n, addr, hlda, dma_req,
        output ready_n, na_n, hold, dma_gnt, mem_sel, rom_sel, io_sel, status_led
    );
    modport master (
        output t_tick, ads_n, mio, dc, wr, lock_n, addr, hlda, dma_req,
        input  ready_n, na_n, hold, dma_gnt, mem_sel, rom_sel, io_sel, status_led
    );
endinterface

// File: rtl/am386_cycle_ctrl.sv
// am386_cycle_ctrl: 386 bus cycle decoder, wait-state READY# generator and HOLD arbiter
// All state advances only on SYS_CLK edges qualified by t_tick.
module am386_cycle_ctrl #(
    parameter int          MEM_WS   = 1,
    parameter int          ROM_WS   = 3,
    parameter int          IO_WS    = 4,
    parameter logic [7:0]  ROM_PAGE = 8'hFF,
    parameter int          HOLD_TO  = 16
) (
    input  logic               SYS_CLK,
    input  logic               user_reset_button,
    am386_cycle_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WAIT, RDY, HREQ, HGNT, HREL} state_t;
    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] hto_q, hto_d;
    logic [2:0]  sel_q, sel_d;
    logic [3:0]  last_q, last_d;
    logic        err_q, err_d, halt_q, halt_d;
    logic        is_halt, is_rom, is_mem, is_io;
    logic [3:0]  ws;
    assign is_halt = bus.mio & ~bus.dc & bus.wr;
    assign is_rom  = bus.mio & ~is_halt & (bus.addr[23:16] == ROM_PAGE);
    assign is_mem  = bus.mio & ~is_halt & ~is_rom;
    assign is_io   = ~bus.mio & bus.dc;
    // interrupt acknowledge shares IO_WS but asserts no select
    assign ws = is_halt ? 4'd0 : !bus.mio ? 4'(IO_WS) : is_rom ? 4'(ROM_WS) : 4'(MEM_WS);
    always_ff @(posedge SYS_CLK or posedge user_reset_button) begin
        if (user_reset_button) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hto_q   <= '0;
            sel_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hto_q   <= hto_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            err_q   <= err_d;
            halt_q  <= halt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hto_d   = hto_q;
        sel_d   = sel_q;
        last_d  = last_q;
        err_d   = err_q;
        halt_d  = halt_q;
        if (bus.t_tick) begin
            case (state_q)
                IDLE, RDY: begin
                    state_d = IDLE;
                    sel_d   = '0;
                    if (!bus.ads_n) begin
                        sel_d   = {is_mem, is_rom, is_io};
                        last_d  = {bus.mio, bus.dc, bus.wr, is_rom};
                        halt_d  = halt_q | is_halt;
                        cnt_d   = ws;
                        state_d = (ws == 4'd0) ? RDY : WAIT;
                    end else if (state_q == IDLE && bus.dma_req && bus.lock_n) begin
                        hto_d   = '0;
                        state_d = HREQ;
                    end
                end
                WAIT: begin
                    cnt_d   = cnt_q - 4'd1;
                    state_d = (cnt_q == 4'd1) ? RDY : WAIT;
                end
                HREQ: begin
                    if (bus.hlda) begin
                        state_d = HGNT;
                    end else if (hto_q == 16'(HOLD_TO - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        hto_d = hto_q + 16'd1;
                    end
                end
                HGNT: begin
                    err_d   = err_q | ~bus.ads_n;
                    state_d = bus.dma_req ? HGNT : HREL;
                end
                HREL: begin
                    err_d   = err_q | ~bus.ads_n;
                    state_d = bus.hlda ? HREL : IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end
    assign bus.ready_n    = (state_q != RDY);
    assign bus.na_n       = 1'b1;
    assign bus.hold       = (state_q == HREQ) || (state_q == HGNT);
    assign bus.dma_gnt    = (state_q == HGNT);
    assign {bus.mem_sel, bus.rom_sel, bus.io_sel} = sel_q;
    assign bus.status_led = {last_q, err_q, halt_q, state_q == HGNT, state_q != IDLE};
endmodule

// File: tb/tb_am386_cycle_ctrl.sv
// tb_am386_cycle_ctrl: directed checks of decode, wait-state timing, arbitration and reset
module tb_am386_cycle_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;
    am386_cycle_ctrl_if bus();
    am386_cycle_ctrl dut (.SYS_CLK(clk), .user_reset_button(rst), .bus(bus));
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one qualified edge followed by one unqualified edge; returns at a negedge
    task automatic tick();
        @(negedge clk) bus.t_tick = 1'b1;
        @(negedge clk) bus.t_tick = 1'b0;
    endtask

    task automatic start(input logic m, input logic d, input logic w, input logic [23:1] a);
        bus.mio = m; bus.dc = d; bus.wr = w; bus.addr = a; bus.ads_n = 1'b0;
        tick();
        bus.ads_n = 1'b1;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk) rst = 1'b0;
    endtask

    initial begin
        bus.t_tick = 0; bus.ads_n = 1; bus.mio = 0; bus.dc = 0; bus.wr = 0;
        bus.lock_n = 1; bus.addr = '0; bus.hlda = 0; bus.dma_req = 0;
        repeat (2) @(negedge clk);
        check("rst_ready_n", bus.ready_n, 1);
        check("rst_na_n", bus.na_n, 1);
        check("rst_hold_gnt", {bus.hold, bus.dma_gnt}, 0);
        check("rst_sels", {bus.mem_sel, bus.rom_sel, bus.io_sel}, 0);
        check("rst_led", bus.status_led, 8'h00);
        release_reset();
        // ADS without a tick must be ignored
        bus.mio = 1; bus.dc = 1; bus.wr = 0; bus.addr = 23'h000800; bus.ads_n = 0;
        repeat (3) @(negedge clk);
        check("no_tick_idle", bus.status_led, 8'h00);
        // memory read, MEM_WS=1
        start(1, 1, 0, 23'h000800);
        check("mem_k_sel", bus.mem_sel, 1);
        check("mem_k_ready", bus.ready_n, 1);
        check("mem_k_led", bus.status_led, 8'hC1);
        tick();
        check("mem_k1_ready", bus.ready_n, 0);
        tick();
        check("mem_k2_ready", bus.ready_n, 1);
        check("mem_k2_sel", bus.mem_sel, 0);
        check("mem_k2_led", bus.status_led, 8'hC0);
        // ROM fetch at 0xFFFFF0, ROM_WS=3
        start(1, 0, 0, 23'h7FFFF8);
        check("rom_k_sels", {bus.mem_sel, bus.rom_sel, bus.io_sel}, 3'b010);
        check("rom_k_led", bus.status_led, 8'h91);
        tick();
        check("rom_k1_ready", bus.ready_n, 1);
        tick();
        check("rom_k2_ready", bus.ready_n, 1);
        tick();
        check("rom_k3_ready", bus.ready_n, 0);
        // back-to-back: interrupt acknowledge accepted on the RDY-exit tick
        start(0, 0, 0, 23'h000000);
        check("inta_ready", bus.ready_n, 1);
        check("inta_sels", {bus.mem_sel, bus.rom_sel, bus.io_sel}, 0);
        check("inta_led", bus.status_led, 8'h01);
        repeat (3) tick();
        check("inta_k3_ready", bus.ready_n, 1);
        tick();
        check("inta_k4_ready", bus.ready_n, 0);
        tick();
        check("inta_done", bus.status_led[0], 0);
        // CPU cycle wins over a simultaneous dma_req
        bus.dma_req = 1;
        start(1, 1, 0, 23'h000800);
        bus.dma_req = 0;
        check("cpu_wins_hold", bus.hold, 0);
        check("cpu_wins_sel", bus.mem_sel, 1);
        tick();
        check("cpu_wins_ready", bus.ready_n, 0);
        tick();
        // reset during WAIT of an I/O cycle
        start(0, 1, 1, 23'h000040);
        check("io_sel", bus.io_sel, 1);
        tick();
        pulse_reset();
        check("io_rst_ready", bus.ready_n, 1);
        check("io_rst_sel", bus.io_sel, 0);
        check("io_rst_led", bus.status_led, 8'h00);
        release_reset();
        start(1, 1, 0, 23'h000800);
        check("post_rst_sel", bus.mem_sel, 1);
        tick();
        check("post_rst_ready", bus.ready_n, 0);
        tick();
        // halt cycle at a ROM-page address: zero wait, no select, sticky halt
        start(1, 0, 1, 23'h7FFFF8);
        check("halt_ready", bus.ready_n, 0);
        check("halt_sels", {bus.mem_sel, bus.rom_sel, bus.io_sel}, 0);
        check("halt_led", bus.status_led, 8'hA5);
        tick();
        check("halt_k1_ready", bus.ready_n, 1);
        check("halt_sticky", bus.status_led, 8'hA4);
        // hold blocked by lock, then granted and released
        bus.dma_req = 1; bus.lock_n = 0;
        tick();
        check("lock_hold", bus.hold, 0);
        bus.lock_n = 1;
        tick();
        check("hreq_hold", bus.hold, 1);
        check("hreq_gnt", bus.dma_gnt, 0);
        bus.hlda = 1;
        tick();
        check("hgnt_gnt", bus.dma_gnt, 1);
        check("hgnt_led", bus.status_led, 8'hA7);
        bus.ads_n = 0;
        tick();
        bus.ads_n = 1;
        check("hgnt_ads_err", bus.status_led, 8'hAF);
        bus.dma_req = 0;
        tick();
        check("hrel_hold_gnt", {bus.hold, bus.dma_gnt}, 0);
        check("hrel_led", bus.status_led, 8'hAD);
        bus.hlda = 0;
        tick();
        check("hrel_idle", bus.status_led, 8'hAC);
        // hold timeout after HOLD_TO ticks without hlda
        pulse_reset();
        release_reset();
        bus.dma_req = 1;
        tick();
        bus.dma_req = 0;
        check("to_hold", bus.hold, 1);
        repeat (15) tick();
        check("to_15_hold", bus.hold, 1);
        tick();
        check("to_16_hold", bus.hold, 0);
        check("to_err", bus.status_led[3], 1);
        // reset while granted
        bus.dma_req = 1;
        tick();
        bus.hlda = 1;
        tick();
        check("mid_hold_gnt", bus.dma_gnt, 1);
        pulse_reset();
        check("mid_hold_rst", {bus.hold, bus.dma_gnt}, 0);
        check("mid_hold_led", bus.status_led, 8'h00);
        bus.dma_req = 0; bus.hlda = 0;
        release_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
